spi_daisy_chain_n: RTL and testbench

- Parametrised SPI daisy chain: one SPI master plus N_DEV shift-register slaves on a single clock.
- One transaction shifts an N_DEV*DATA_W-bit frame through the chain.
- After each frame, every slave holds its own word and the master returns the chain's previous contents.
- Generalises the fixed 8-bit, fixed-length chain in width, device count and SCLK rate, and adds busy/done handshaking and readback.

---
 rtl/spi_daisy_chain_n.sv | 164 ++++++++++++++++
 tb/tb_spi_daisy_chain_n.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_daisy_chain_n.sv
// SPI master driving a chain of N_DEV shift-register slaves, with busy/done handshake and readback.
// Define SPI_LSB_FIRST_EN to send frames LSB-first (slaves shift right); default is MSB-first.
module spi_daisy_chain_n #(
    parameter int DATA_W  = 8,
    parameter int N_DEV   = 3,
    parameter int CLK_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      newd,
    input  logic [N_DEV*DATA_W-1:0]   din,
    output logic [N_DEV*DATA_W-1:0]   dout,
    output logic [N_DEV*DATA_W-1:0]   slave_q,
    output logic                      busy,
    output logic                      done,
    output logic                      sclk,
    output logic                      cs,
    output logic                      mosi
);

    localparam int TOTAL = N_DEV * DATA_W;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [DIV_W-1:0]   r_div;
    logic [CNT_W-1:0]   r_bits;
    logic [TOTAL-1:0]   r_tx, r_rx, r_chain, r_dout;
    logic               r_busy, r_done, r_sclk, r_cs, r_mosi;

    logic               w_div_end, w_accept, w_start, w_rise, w_fall, w_last, w_enter_done;
    logic               w_miso, w_tx_bit;
    logic [TOTAL-1:0]   w_chain_nxt, w_rx_nxt;

    assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));

`ifdef SPI_LSB_FIRST_EN
    // r_chain holds {slave0, ..., slaveN-1}; re-pack so slave k sits at word k of slave_q
    assign w_miso      = r_chain[0];
    assign w_tx_bit    = r_tx[0];
    assign w_chain_nxt = (r_chain >> 1) | (TOTAL'(r_mosi) << (TOTAL - 1));
    assign w_rx_nxt    = (r_rx >> 1) | (TOTAL'(w_miso) << (TOTAL - 1));
    for (genvar k = 0; k < N_DEV; k++) begin : g_repack
        assign slave_q[k*DATA_W +: DATA_W] = r_chain[(N_DEV-1-k)*DATA_W +: DATA_W];
    end
`else
    assign w_miso      = r_chain[TOTAL-1];
    assign w_tx_bit    = r_tx[TOTAL-1];
    assign w_chain_nxt = (r_chain << 1) | TOTAL'(r_mosi);
    assign w_rx_nxt    = (r_rx << 1) | TOTAL'(w_miso);
    assign slave_q     = r_chain;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // IDLE with busy already set is the one-cycle gap between accept and asserting cs
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_start      = 1'b0;
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        w_last       = 1'b0;
        w_enter_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_busy) begin
                    w_start     = 1'b1;
                    w_state_nxt = SHIFT;
                end else if (newd) begin
                    w_accept = 1'b1;
                end
            end
            SHIFT: begin
                if (w_div_end) begin
                    if (!r_sclk) begin
                        w_rise = 1'b1;
                    end else begin
                        w_fall = 1'b1;
                        if (r_bits == CNT_W'(TOTAL - 1)) begin
                            w_last      = 1'b1;
                            w_state_nxt = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (w_div_end) begin
                    w_enter_done = 1'b1;
                    w_state_nxt  = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_bits  <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_chain <= '0;
            r_dout  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_cs    <= 1'b1;
            r_mosi  <= 1'b0;
        end else begin
            if (r_state == SHIFT || r_state == HOLD)
                r_div <= w_div_end ? '0 : r_div + 1'b1;
            else
                r_div <= '0;

            r_done <= w_enter_done;
            if (r_state == DONE) r_busy <= 1'b0;

            if (w_accept) begin
                r_tx   <= din;
                r_busy <= 1'b1;
            end
            if (w_start) begin
                r_cs   <= 1'b0;
                r_mosi <= w_tx_bit;
                r_bits <= '0;
            end
            // tx advances on the rising edge so its leading bit is already the next one at the fall
            if (w_rise) begin
                r_sclk  <= 1'b1;
                r_chain <= w_chain_nxt;
                r_rx    <= w_rx_nxt;
`ifdef SPI_LSB_FIRST_EN
                r_tx    <= r_tx >> 1;
`else
                r_tx    <= r_tx << 1;
`endif
            end
            if (w_fall) begin
                r_sclk <= 1'b0;
                r_bits <= r_bits + 1'b1;
                r_mosi <= w_last ? 1'b0 : w_tx_bit;
            end
            if (w_enter_done) begin
                r_cs   <= 1'b1;
                r_dout <= r_rx;
            end
        end
    end

    assign dout = r_dout;
    assign busy = r_busy;
    assign done = r_done;
    assign sclk = r_sclk;
    assign cs   = r_cs;
    assign mosi = r_mosi;

endmodule

// File: tb/tb_spi_daisy_chain_n.sv
// Directed bench for spi_daisy_chain_n: table of consecutive frames plus handshake, reset and small-config sequences.
module tb_spi_daisy_chain_n;

`ifdef SPI_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, newd, newd2;
    logic [23:0] din, dout, slave_q;
    logic        busy, done, sclk, cs, mosi;
    logic [3:0]  din2, dout2, slave_q2;
    logic        busy2, done2, sclk2, cs2, mosi2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_daisy_chain_n u_dut (
        .clk(clk), .rst(rst), .newd(newd), .din(din), .dout(dout), .slave_q(slave_q),
        .busy(busy), .done(done), .sclk(sclk), .cs(cs), .mosi(mosi)
    );

    spi_daisy_chain_n #(.DATA_W(4), .N_DEV(1), .CLK_DIV(1)) u_dut2 (
        .clk(clk), .rst(rst), .newd(newd2), .din(din2), .dout(dout2), .slave_q(slave_q2),
        .busy(busy2), .done(done2), .sclk(sclk2), .cs(cs2), .mosi(mosi2)
    );

    typedef struct {
        logic [23:0] din;
        logic [23:0] slv;
        logic [23:0] dout;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accept at edge T, then count edges until done is seen (bounded)
    task automatic run_frame(input logic [23:0] d, input bit hold, output int cyc, output int rises,
                             output bit cs_ok, output logic first_mosi, output logic busy_acc);
        logic prev;
        @(negedge clk);
        din  = d;
        newd = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) newd = 1'b0;
        din        = ~d;
        busy_acc   = busy;
        cyc        = 0;
        rises      = 0;
        cs_ok      = 1'b1;
        first_mosi = 1'bx;
        prev       = sclk;
        while (done !== 1'b1 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) first_mosi = mosi;
            if (done !== 1'b1 && cs !== 1'b0) cs_ok = 1'b0;
            if (sclk === 1'b1 && prev === 1'b0) rises++;
            prev = sclk;
        end
    endtask

    initial begin
        int   cyc, rises;
        bit   cs_ok, saw_done;
        logic fm, bacc, prev;

        vecs[0] = '{24'hA7_3C_5E, LSB ? 24'h5E_3C_A7 : 24'hA7_3C_5E, 24'h00_00_00};
        vecs[1] = '{24'h12_34_56, LSB ? 24'h56_34_12 : 24'h12_34_56, 24'hA7_3C_5E};
        vecs[2] = '{24'hFF_FF_FF, 24'hFF_FF_FF,                      24'h12_34_56};
        vecs[3] = '{24'h00_00_01, LSB ? 24'h01_00_00 : 24'h00_00_01, 24'hFF_FF_FF};
        vecs[4] = '{24'h80_00_00, LSB ? 24'h00_00_80 : 24'h80_00_00, 24'h00_00_01};

        rst = 1'b1; newd = 1'b0; din = '0; newd2 = 1'b0; din2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_slave_q", slave_q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_cs", cs, 1);
        chk("rst_mosi", mosi, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].din, 1'b0, cyc, rises, cs_ok, fm, bacc);
            chk($sformatf("v%0d_latency", i), cyc, 197);
            chk($sformatf("v%0d_sclk_rises", i), rises, 24);
            chk($sformatf("v%0d_cs_low", i), cs_ok, 1);
            chk($sformatf("v%0d_busy_accept", i), bacc, 1);
            chk($sformatf("v%0d_slave_q", i), slave_q, vecs[i].slv);
            chk($sformatf("v%0d_dout", i), dout, vecs[i].dout);
            chk($sformatf("v%0d_cs_done", i), cs, 1);
            chk($sformatf("v%0d_busy_done", i), busy, 1);
            if (i == 0) begin
                chk("first_mosi", fm, LSB ? 1'b0 : 1'b1);
                chk("slave0_word", slave_q[7:0], LSB ? 8'hA7 : 8'h5E);
                chk("slave2_word", slave_q[23:16], LSB ? 8'h5E : 8'hA7);
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_busy_after", i), busy, 0);
            chk($sformatf("v%0d_done_pulse", i), done, 0);
        end

        // newd held high through the frame and the done cycle: exactly one frame
        run_frame(24'h5A_5A_C3, 1'b1, cyc, rises, cs_ok, fm, bacc);
        chk("hold_latency", cyc, 197);
        chk("hold_busy_done", busy, 1);
        @(posedge clk);
        #1;
        chk("hold_busy_drop", busy, 0);
        @(negedge clk);
        newd = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("hold_no_requeue_busy", busy, 0);
        chk("hold_no_requeue_cs", cs, 1);
        chk("hold_slave_q", slave_q, LSB ? 24'hC3_5A_5A : 24'h5A_5A_C3);
        chk("hold_dout", dout, 24'h80_00_00);

        // reset during bit 10 aborts the frame
        @(negedge clk);
        din  = 24'hC3_C3_C3;
        newd = 1'b1;
        @(posedge clk);
        #1;
        newd     = 1'b0;
        rises    = 0;
        saw_done = 1'b0;
        prev     = sclk;
        for (int i = 0; i < 2000 && rises < 10; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
            if (sclk === 1'b1 && prev === 1'b0) rises++;
            prev = sclk;
        end
        chk("abort_reached_bit10", rises, 10);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_cs", cs, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_slave_q", slave_q, 0);
        chk("abort_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        if (done === 1'b1) saw_done = 1'b1;
        chk("abort_no_done", saw_done, 0);
        @(negedge clk);
        rst = 1'b0;

        run_frame(24'hFF_00_FF, 1'b0, cyc, rises, cs_ok, fm, bacc);
        chk("post_abort_latency", cyc, 197);
        chk("post_abort_slave_q", slave_q, 24'hFF_00_FF);
        chk("post_abort_dout", dout, 0);

        // single 4-bit slave, CLK_DIV=1: done at T+10
        @(negedge clk);
        din2  = 4'h9;
        newd2 = 1'b1;
        @(posedge clk);
        #1;
        newd2 = 1'b0;
        cyc   = 0;
        while (done2 !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("small_latency", cyc, 10);
        chk("small_slave_q", slave_q2, 4'h9);
        chk("small_dout", dout2, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
